// File: rtl/uart_rom_loader.sv
// uart_rom_loader: 8N1 UART bootloader that writes a framed image into the ROM.
// The CPU is held in reset while a frame loads and after any load error.
//   clk      : system clock
//   reset    : asynchronous, active-high reset
//   rx       : UART receive line, asynchronous, idles high
//   wr_en    : ROM write strobe, one-cycle pulse
//   wr_addr  : ROM word address
//   wr_data  : ROM word data, {hi_byte, lo_byte}
//   cpu_hold : high while a frame loads or after an error
//   done     : high after a good load; cleared by the next sync byte
//   err_code : 0 ok, 1 framing, 2 length, 3 checksum (sticky)
module uart_rom_loader #(
    parameter int          CLKS_PER_BIT       = 434,
    parameter int          INSTR_WIDTH        = 16,
    parameter int          ROM_REGISTER_COUNT = 1024,
    parameter logic [7:0]  SYNC_BYTE          = 8'hA5,
    localparam int         AW = $clog2(ROM_REGISTER_COUNT)
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   rx,
    output logic                   wr_en,
    output logic [AW-1:0]          wr_addr,
    output logic [INSTR_WIDTH-1:0] wr_data,
    output logic                   cpu_hold,
    output logic                   done,
    output logic [1:0]             err_code
);

    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] FULL = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] HALF = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [16:0]   LEN_MAX = 17'(ROM_REGISTER_COUNT);

    typedef enum logic [1:0] {B_IDLE, B_START, B_DATA, B_STOP} bstate_t;
    typedef enum logic [2:0] {
        F_SYNC, F_LEN_LO, F_LEN_HI, F_DATA_LO, F_DATA_HI, F_CSUM, F_ERR
    } fstate_t;

    // ---------------- receiver ----------------
    logic          rx_s1_q, rx_s2_q, rx_prev_q;
    bstate_t       bstate_q, bstate_d;
    logic [CW-1:0] bcnt_q, bcnt_d;
    logic [2:0]    bits_q, bits_d;
    logic [7:0]    sh_q, sh_d;
    logic          bv_q, bv_d;
    logic          fe_q, fe_d;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rx_s1_q   <= 1'b1;
            rx_s2_q   <= 1'b1;
            rx_prev_q <= 1'b1;
            bstate_q  <= B_IDLE;
            bcnt_q    <= '0;
            bits_q    <= '0;
            sh_q      <= '0;
            bv_q      <= 1'b0;
            fe_q      <= 1'b0;
        end else begin
            rx_s1_q   <= rx;
            rx_s2_q   <= rx_s1_q;
            rx_prev_q <= rx_s2_q;
            bstate_q  <= bstate_d;
            bcnt_q    <= bcnt_d;
            bits_q    <= bits_d;
            sh_q      <= sh_d;
            bv_q      <= bv_d;
            fe_q      <= fe_d;
        end
    end

    always_comb begin
        bstate_d = bstate_q;
        bcnt_d   = bcnt_q + 1'b1;
        bits_d   = bits_q;
        sh_d     = sh_q;
        bv_d     = 1'b0;
        fe_d     = 1'b0;
        unique case (bstate_q)
            B_IDLE: begin
                bcnt_d = '0;
                bits_d = '0;
                if (rx_prev_q && !rx_s2_q) bstate_d = B_START;
            end
            B_START: begin
                // Mid-start-bit check rejects short low glitches.
                if (bcnt_q == HALF) begin
                    bcnt_d   = '0;
                    bstate_d = rx_s2_q ? B_IDLE : B_DATA;
                end
            end
            B_DATA: begin
                if (bcnt_q == FULL) begin
                    bcnt_d = '0;
                    sh_d   = {rx_s2_q, sh_q[7:1]};
                    bits_d = bits_q + 1'b1;
                    if (bits_q == 3'd7) bstate_d = B_STOP;
                end
            end
            B_STOP: begin
                if (bcnt_q == FULL) begin
                    bcnt_d   = '0;
                    bstate_d = B_IDLE;
                    bv_d     = rx_s2_q;
                    fe_d     = !rx_s2_q;
                end
            end
            default: bstate_d = B_IDLE;
        endcase
    end

    // ---------------- frame parser ----------------
    fstate_t          fstate_q, fstate_d;
    logic [15:0]      len_q, len_d;
    logic [15:0]      wcnt_q, wcnt_d;
    logic [7:0]       lo_q, lo_d;
    logic [7:0]       csum_q, csum_d;
    logic [AW-1:0]    addr_q, addr_d;
    logic [INSTR_WIDTH-1:0] data_q, data_d;
    logic             wr_en_q, wr_en_d;
    logic             hold_q, hold_d;
    logic             done_q, done_d;
    logic [1:0]       err_q, err_d;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            fstate_q <= F_SYNC;
            len_q    <= '0;
            wcnt_q   <= '0;
            lo_q     <= '0;
            csum_q   <= '0;
            addr_q   <= '0;
            data_q   <= '0;
            wr_en_q  <= 1'b0;
            hold_q   <= 1'b0;
            done_q   <= 1'b0;
            err_q    <= 2'd0;
        end else begin
            fstate_q <= fstate_d;
            len_q    <= len_d;
            wcnt_q   <= wcnt_d;
            lo_q     <= lo_d;
            csum_q   <= csum_d;
            addr_q   <= addr_d;
            data_q   <= data_d;
            wr_en_q  <= wr_en_d;
            hold_q   <= hold_d;
            done_q   <= done_d;
            err_q    <= err_d;
        end
    end

    always_comb begin
        fstate_d = fstate_q;
        len_d    = len_q;
        wcnt_d   = wcnt_q;
        lo_d     = lo_q;
        csum_d   = csum_q;
        addr_d   = addr_q;
        data_d   = data_q;
        wr_en_d  = 1'b0;
        hold_d   = hold_q;
        done_d   = done_q;
        err_d    = err_q;
        // Advance after a write, but never beyond the last word of the image.
        if (wr_en_q && wcnt_q < len_q) addr_d = addr_q + 1'b1;
        if (fe_q && fstate_q != F_SYNC && fstate_q != F_ERR) begin
            err_d    = 2'd1;
            fstate_d = F_ERR;
        end else if (bv_q) begin
            unique case (fstate_q)
                F_SYNC, F_ERR: begin
                    if (sh_q == SYNC_BYTE) begin
                        hold_d   = 1'b1;
                        done_d   = 1'b0;
                        err_d    = 2'd0;
                        csum_d   = '0;
                        addr_d   = '0;
                        wcnt_d   = '0;
                        fstate_d = F_LEN_LO;
                    end
                end
                F_LEN_LO: begin
                    len_d    = {len_q[15:8], sh_q};
                    csum_d   = csum_q + sh_q;
                    fstate_d = F_LEN_HI;
                end
                F_LEN_HI: begin
                    len_d  = {sh_q, len_q[7:0]};
                    csum_d = csum_q + sh_q;
                    if ({1'b0, len_d} > LEN_MAX) begin
                        err_d    = 2'd2;
                        fstate_d = F_ERR;
                    end else if (len_d == 16'd0) begin
                        fstate_d = F_CSUM;
                    end else begin
                        fstate_d = F_DATA_LO;
                    end
                end
                F_DATA_LO: begin
                    lo_d     = sh_q;
                    csum_d   = csum_q + sh_q;
                    fstate_d = F_DATA_HI;
                end
                F_DATA_HI: begin
                    csum_d   = csum_q + sh_q;
                    data_d   = {sh_q, lo_q};
                    wr_en_d  = 1'b1;
                    wcnt_d   = wcnt_q + 1'b1;
                    fstate_d = (wcnt_d == len_q) ? F_CSUM : F_DATA_LO;
                end
                F_CSUM: begin
                    if (sh_q == csum_q) begin
                        done_d   = 1'b1;
                        hold_d   = 1'b0;
                        fstate_d = F_SYNC;
                    end else begin
                        err_d    = 2'd3;
                        fstate_d = F_ERR;
                    end
                end
                default: fstate_d = F_SYNC;
            endcase
        end
    end

    assign wr_en    = wr_en_q;
    assign wr_addr  = addr_q;
    assign wr_data  = data_q;
    assign cpu_hold = hold_q;
    assign done     = done_q;
    assign err_code = err_q;

endmodule

// File: tb/tb_uart_rom_loader.sv
// tb_uart_rom_loader: directed frames against uart_rom_loader,
// ROM writes logged from the write port and compared with hand values.
module tb_uart_rom_loader;

    localparam int CPB = 16;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        rx = 1'b1;
    logic        wr_en;
    logic [9:0]  wr_addr;
    logic [15:0] wr_data;
    logic        cpu_hold;
    logic        done;
    logic [1:0]  err_code;

    int n_assert = 0;
    int n_fail   = 0;
    int bad_wr   = 0;

    logic [31:0] log_addr[$];
    logic [31:0] log_data[$];
    logic [7:0]  q[$];

    uart_rom_loader #(
        .CLKS_PER_BIT(CPB)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .rx       (rx),
        .wr_en    (wr_en),
        .wr_addr  (wr_addr),
        .wr_data  (wr_data),
        .cpu_hold (cpu_hold),
        .done     (done),
        .err_code (err_code)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (wr_en) begin
            log_addr.push_back(32'(wr_addr));
            log_data.push_back(32'(wr_data));
            if (!cpu_hold) bad_wr++;
        end
    end

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_assert++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] la(input int i);
        return (i < log_addr.size()) ? log_addr[i] : 32'hDEAD_BEEF;
    endfunction

    function automatic logic [31:0] ld(input int i);
        return (i < log_data.size()) ? log_data[i] : 32'hDEAD_BEEF;
    endfunction

    task automatic clear_log();
        log_addr.delete();
        log_data.delete();
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
    endtask

    task automatic send_byte(input logic [7:0] b, input logic stop);
        rx = 1'b0;
        idle(CPB);
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            idle(CPB);
        end
        rx = stop;
        idle(CPB);
        rx = 1'b1;
        if (!stop) idle(CPB);
    endtask

    task automatic send_q();
        foreach (q[i]) send_byte(q[i], 1'b1);
        idle(2 * CPB);
    endtask

    task automatic status(input string tag, input logic [3:0] exp);
        @(negedge clk);
        check(tag, {28'd0, cpu_hold, done, err_code}, {28'd0, exp});
    endtask

    initial begin
        reset = 1'b1;
        idle(3);
        @(negedge clk);
        check("reset outs",
              {11'd0, wr_en, wr_addr, cpu_hold, done, err_code}, 32'd0);
        check("reset data", {16'd0, wr_data}, 32'd0);
        reset = 1'b0;
        idle(4);

        // 1: two-word image
        clear_log();
        q = '{8'hA5, 8'h02};
        send_q();
        status("t1 loading", 4'b1000);
        q = '{8'h00, 8'h34, 8'h12, 8'h78, 8'h56, 8'h16};
        send_q();
        check("t1 nwr", 32'(log_addr.size()), 32'd2);
        check("t1 a0", la(0), 32'd0);
        check("t1 d0", ld(0), 32'h1234);
        check("t1 a1", la(1), 32'd1);
        check("t1 d1", ld(1), 32'h5678);
        status("t1 status", 4'b0100);

        // 2: junk before sync, empty image
        clear_log();
        q = '{8'h00, 8'hFF};
        send_q();
        status("t2 junk", 4'b0100);
        q = '{8'hA5};
        send_q();
        status("t2 sync", 4'b1000);
        q = '{8'h00, 8'h00, 8'h00};
        send_q();
        check("t2 nwr", 32'(log_addr.size()), 32'd0);
        status("t2 status", 4'b0100);

        // 3: bad checksum, then recovery
        clear_log();
        q = '{8'hA5, 8'h01, 8'h00, 8'hAA, 8'hBB, 8'h00};
        send_q();
        check("t3 nwr", 32'(log_addr.size()), 32'd1);
        check("t3 a0", la(0), 32'd0);
        check("t3 d0", ld(0), 32'hBBAA);
        status("t3 csum err", 4'b1011);
        clear_log();
        q = '{8'hA5, 8'h01, 8'h00, 8'hCD, 8'hAB, 8'h79};
        send_q();
        check("t3b nwr", 32'(log_addr.size()), 32'd1);
        check("t3b d0", ld(0), 32'hABCD);
        status("t3b status", 4'b0100);

        // 4: length 1025 rejected
        clear_log();
        q = '{8'hA5, 8'h01, 8'h04, 8'h11, 8'h22, 8'h33};
        send_q();
        check("t4 nwr", 32'(log_addr.size()), 32'd0);
        status("t4 len err", 4'b1010);

        // 5: bad stop bit on second data byte
        clear_log();
        q = '{8'hA5, 8'h02, 8'h00, 8'h11};
        send_q();
        send_byte(8'h22, 1'b0);
        idle(2 * CPB);
        status("t5 frame err", 4'b1001);
        q = '{8'h33, 8'h44, 8'h55, 8'h66};
        send_q();
        check("t5 nwr", 32'(log_addr.size()), 32'd0);
        status("t5 stays err", 4'b1001);

        // 5b: quarter-bit glitch inside a frame must not make a byte
        clear_log();
        q = '{8'hA5, 8'h01, 8'h00};
        send_q();
        rx = 1'b0;
        idle(CPB / 4);
        rx = 1'b1;
        idle(2 * CPB);
        q = '{8'hCD, 8'hAB, 8'h79};
        send_q();
        check("t5b nwr", 32'(log_addr.size()), 32'd1);
        check("t5b d0", ld(0), 32'hABCD);
        status("t5b status", 4'b0100);

        // 6: reset in the middle of a data byte
        clear_log();
        q = '{8'hA5, 8'h02, 8'h00};
        send_q();
        rx = 1'b0;
        idle(CPB);
        for (int i = 0; i < 4; i++) begin
            rx = i[0];
            idle(CPB);
        end
        #3 reset = 1'b1;
        rx = 1'b1;
        @(negedge clk);
        check("t6 reset outs",
              {11'd0, wr_en, wr_addr, cpu_hold, done, err_code}, 32'd0);
        idle(2);
        @(negedge clk);
        reset = 1'b0;
        idle(4);
        q = '{8'hA5, 8'h01, 8'h00, 8'hEF, 8'hBE, 8'hAE};
        send_q();
        check("t6 nwr", 32'(log_addr.size()), 32'd1);
        check("t6 a0", la(0), 32'd0);
        check("t6 d0", ld(0), 32'hBEEF);
        status("t6 status", 4'b0100);

        check("wr outside frame", 32'(bad_wr), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_assert, n_fail);
        $finish;
    end

endmodule
